// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Scans a common-anode 4-digit 7-segment display that is fed by an external
// 4-digit multiplexer. The block drives the digit index to the multiplexer,
// decodes the digit value it returns, and drives the display pins.
// Every digit change opens a blanking window, so a digit never lights before
// its own segment data reaches the pins.
//
// Optional feature macro: DIM_EN. When it is defined, a `duty` port is added
// and each digit's on-time is shortened to give brightness control.
//
// Parameters:
//   SCAN_DIV      clk cycles each digit stays selected (4 .. 2^20)
//   BLANK_CYCLES  cycles the anodes stay off after each select change
//                 (2 .. SCAN_DIV-1)
//
// Ports:
//   clk     system clock; all logic updates on posedge
//   rst     synchronous active-high reset
//   cnt     [3:0] digit value from the multiplexer, valid 1 cycle after select
//   dot     decimal-point request from the multiplexer, active low
//   duty    [2:0] brightness, 7 = full (only when DIM_EN is defined)
//   select  [1:0] registered digit index to the multiplexer
//   an      [3:0] anode enables, active low; an[i] lights digit i
//   seg     [6:0] registered segments {g,f,e,d,c,b,a}, active low
//   dp      registered decimal point, active low
module seg_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt,
  input  logic       dot,
`ifdef DIM_EN
  input  logic [2:0] duty,
`endif
  output logic [1:0] select,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);

  logic [PW-1:0] presc_reg, presc_next;
  logic [1:0]    sel_reg, sel_next;
  logic [BW-1:0] blank_reg, blank_next;
  logic [6:0]    seg_reg, seg_next;
  logic          dp_reg;
  logic          tick;
  logic          dim_off;
  logic          lit;

  assign tick = (presc_reg == PRESC_MAX);

  always_comb begin
    presc_next = presc_reg + PW'(1);
    sel_next   = sel_reg;
    blank_next = blank_reg;
    if (tick) begin
      presc_next = '0;
      sel_next   = sel_reg + 2'd1;
      // A fresh digit always restarts the blanking window.
      blank_next = BLANK_LOAD;
    end else if (blank_reg != '0) begin
      blank_next = blank_reg - BW'(1);
    end
  end

  // Hex decode, active low {g,f,e,d,c,b,a}. Unknown input leaves all segments dark.
  always_comb begin
    seg_next = 7'b1111111;
    case (cnt)
      4'h0: seg_next = 7'b1000000;
      4'h1: seg_next = 7'b1111001;
      4'h2: seg_next = 7'b0100100;
      4'h3: seg_next = 7'b0110000;
      4'h4: seg_next = 7'b0011001;
      4'h5: seg_next = 7'b0010010;
      4'h6: seg_next = 7'b0000010;
      4'h7: seg_next = 7'b1111000;
      4'h8: seg_next = 7'b0000000;
      4'h9: seg_next = 7'b0010000;
      4'hA: seg_next = 7'b0001000;
      4'hB: seg_next = 7'b0000011;
      4'hC: seg_next = 7'b1000110;
      4'hD: seg_next = 7'b0100001;
      4'hE: seg_next = 7'b0000110;
      4'hF: seg_next = 7'b0001110;
      default: seg_next = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg <= '0;
      sel_reg   <= 2'd0;
      blank_reg <= BLANK_LOAD;
      seg_reg   <= 7'b1111111;
      dp_reg    <= 1'b1;
    end else begin
      presc_reg <= presc_next;
      sel_reg   <= sel_next;
      blank_reg <= blank_next;
      seg_reg   <= seg_next;
      dp_reg    <= dot;
    end
  end

`ifdef DIM_EN
  // duty is registered so the anode decode depends only on internal state.
  // It simply follows the port and needs no reset value.
  logic [2:0]  duty_reg;
  logic [31:0] on_limit;

  always_ff @(posedge clk) begin
    duty_reg <= duty;
  end

  // The prescaler is zero at the start of every digit period, so it also
  // serves as the position within the current digit.
  always_comb begin
    on_limit = 32'(BLANK_CYCLES)
             + ((32'(duty_reg) + 32'd1) * 32'(SCAN_DIV - BLANK_CYCLES)) / 32'd8;
    dim_off  = (32'(presc_reg) >= on_limit);
  end
`else
  assign dim_off = 1'b0;
`endif

  assign lit = (blank_reg == '0) && !dim_off;

  // One-hot active-low anode decode taken only from registered state.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_anode
      assign an[gi] = ~(lit && (sel_reg == 2'(gi)));
    end
  endgenerate

  assign select = sel_reg;
  assign seg    = seg_reg;
  assign dp     = dp_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       chk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mux_cnt = 4'h0;
  logic       mux_dot = 1'b1;
  logic [1:0] select;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int   checks   = 0;
  int   failures = 0;
  int   t        = 0;
  exp_t sb_q[$];

  logic [3:0] frames [4][4];
  logic [3:0] digits [4];
  logic [6:0] seg_tab [16];

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .cnt(mux_cnt),
    .dot(mux_dot),
`ifdef DIM_EN
    .duty(3'd7),
`endif
    .select(select),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  // Behavioural 4-digit multiplexer: registered digit value and dot.
  always @(posedge clk) begin
    mux_cnt <= digits[select];
    mux_dot <= (select == 2'd3) ? 1'b0 : 1'b1;
  end

`ifdef DIM_EN
  logic       dim_rst = 1'b1;
  logic [2:0] dim_duty = 3'd3;
  logic [1:0] dim_select;
  logic [3:0] dim_an;
  logic [6:0] dim_seg;
  logic       dim_dp;
  logic [3:0] dim_q[$];

  seg_scan_driver #(.SCAN_DIV(10), .BLANK_CYCLES(2)) u_dim (
    .clk(clk),
    .rst(dim_rst),
    .cnt(4'h0),
    .dot(1'b1),
    .duty(dim_duty),
    .select(dim_select),
    .an(dim_an),
    .seg(dim_seg),
    .dp(dim_dp)
  );
`endif

  // Expected outputs at cycle tt after reset release (SCAN_DIV=4, BLANK=2).
  function automatic exp_t model(input int tt);
    exp_t e;
    int   s;
    int   ph;
    s     = (tt / 4) % 4;
    ph    = tt % 4;
    e.sel = 2'(s);
    e.chk = (ph >= 2);
    e.an  = e.chk ? ~(4'b0001 << s) : 4'b1111;
    e.seg = seg_tab[frames[(tt / 16) % 4][s]];
    e.dp  = (s == 3) ? 1'b0 : 1'b1;
    return e;
  endfunction

  task automatic step(input logic r);
    exp_t e;
    exp_t g;
    int   nt;
    rst = r;
    if (r) begin
      nt    = 0;
      e.sel = 2'd0;
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
      e.dp  = 1'b1;
      e.chk = 1'b1;
    end else begin
      nt = t + 1;
      e  = model(nt);
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    t = nt;
    checks++;
    assert (select === g.sel) else begin
      failures++;
      $error("FAIL select t=%0d got=%0d exp=%0d", t, select, g.sel);
    end
    checks++;
    assert (an === g.an) else begin
      failures++;
      $error("FAIL an t=%0d got=%b exp=%b", t, an, g.an);
    end
    if (g.chk) begin
      checks++;
      assert (seg === g.seg) else begin
        failures++;
        $error("FAIL seg t=%0d an=%b got=%b exp=%b", t, an, seg, g.seg);
      end
      checks++;
      assert (dp === g.dp) else begin
        failures++;
        $error("FAIL dp t=%0d an=%b got=%b exp=%b", t, an, dp, g.dp);
      end
    end
    $display("cycle t=%0d rst=%0b select=%0d an=%b seg=%b dp=%b", t, r, select, an, seg, dp);
    if (t % 16 == 0) digits = frames[(t / 16) % 4];
  endtask

  initial begin
    frames = '{'{4'h8, 4'h1, 4'hF, 4'h0},
               '{4'h2, 4'h3, 4'h4, 4'h5},
               '{4'h6, 4'h7, 4'h9, 4'hA},
               '{4'hB, 4'hC, 4'hD, 4'hE}};
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    digits = frames[0];

    // Reset held for 3 cycles.
    repeat (3) step(1'b1);
    // Four full frames: scan order, blanking and all 16 decodes.
    repeat (64) step(1'b0);
    // Advance into digit 2's lit window, then reset mid-digit.
    repeat (10) step(1'b0);
    step(1'b1);
    // Digit 0 must light again 2 cycles after release.
    repeat (12) step(1'b0);

`ifdef DIM_EN
    begin
      int td;
      int d;
      int p;
      logic [3:0] ea;
      logic [3:0] ga;
      dim_duty = 3'd3;
      dim_rst  = 1'b1;
      @(posedge clk);
      #1;
      dim_rst = 1'b0;
      td = 0;
      d  = 3;
      for (int i = 0; i < 40; i++) begin
        // duty change is driven before the edge and applies after it.
        if (i == 20) begin
          dim_duty = 3'd7;
          d = 7;
        end
        td++;
        p  = td % 10;
        ea = (p >= 2 && p < 2 + ((d + 1) * 8) / 8) ? ~(4'b0001 << ((td / 10) % 4)) : 4'b1111;
        dim_q.push_back(ea);
        @(posedge clk);
        #1;
        ga = dim_q.pop_front();
        checks++;
        assert (dim_an === ga) else begin
          failures++;
          $error("FAIL dim_an t=%0d duty=%0d got=%b exp=%b", td, d, dim_an, ga);
        end
        $display("dim cycle t=%0d duty=%0d select=%0d an=%b", td, d, dim_select, dim_an);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
